// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: waits for camera config, drops settling frames, then packs
// the 8-bit RGB565 byte stream into tagged 16-bit pixels. Single PCLK domain.
module ov7670_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_WAIT = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cfg_done,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic [15:0] o_pixel,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int FW = (FRAME_WAIT < 1) ? 1 : $clog2(FRAME_WAIT + 1);

  typedef enum logic [1:0] {S_WAIT_CFG, S_SKIP, S_ARMED, S_ACTIVE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cfg_meta, r_cfg_s;
  logic            r_vsync_q, r_href_q;
  logic            r_phase;
  logic [7:0]      r_hi;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [FW-1:0]   r_frame_cnt;
  logic            r_sof_pend;
  logic            r_valid, r_sof, r_eol, r_frame_done, r_err;
  logic [15:0]     r_pixel;

  logic            w_vs_rise, w_vs_fall, w_line_end;
  logic [FW-1:0]   w_fcnt_inc;
  logic [YW-1:0]   w_y_inc, w_y_end;
  logic            w_pix_ok;

  assign w_vs_rise  = ~r_vsync_q & i_vsync;
  assign w_vs_fall  = r_vsync_q & ~i_vsync;
  // A frame ending mid-line closes that line before the frame itself.
  assign w_line_end = (r_href_q & ~i_href) | (w_vs_rise & i_href);
  assign w_fcnt_inc = r_frame_cnt + FW'(1);
  assign w_y_inc    = (r_y == YW'(V_ACTIVE)) ? r_y : r_y + YW'(1);
  assign w_y_end    = w_line_end ? w_y_inc : r_y;
  assign w_pix_ok   = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cfg_meta <= 1'b0;
      r_cfg_s    <= 1'b0;
      r_vsync_q  <= 1'b0;
      r_href_q   <= 1'b0;
    end else begin
      r_cfg_meta <= i_cfg_done;
      r_cfg_s    <= r_cfg_meta;
      r_vsync_q  <= i_vsync;
      r_href_q   <= i_href;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_WAIT_CFG;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!r_cfg_s) begin
      w_state_nxt = S_WAIT_CFG;
    end else begin
      case (r_state)
        S_WAIT_CFG: w_state_nxt = (FRAME_WAIT == 0) ? S_ARMED : S_SKIP;
        S_SKIP:     if (w_vs_rise && (w_fcnt_inc == FW'(FRAME_WAIT))) w_state_nxt = S_ARMED;
        S_ARMED:    if (w_vs_fall) w_state_nxt = S_ACTIVE;
        S_ACTIVE:   if (w_vs_rise) w_state_nxt = S_ARMED;
        default:    w_state_nxt = S_WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_cnt  <= '0;
      r_sof_pend   <= 1'b0;
      r_valid      <= 1'b0;
      r_pixel      <= '0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      if (!r_cfg_s) begin
        // Losing config abandons the frame silently.
        r_phase     <= 1'b0;
        r_x         <= '0;
        r_y         <= '0;
        r_frame_cnt <= '0;
        r_sof_pend  <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT_CFG: r_frame_cnt <= '0;
          S_SKIP:     if (w_vs_rise) r_frame_cnt <= w_fcnt_inc;
          S_ARMED: begin
            if (w_vs_fall) begin
              r_x        <= '0;
              r_y        <= '0;
              r_phase    <= 1'b0;
              r_sof_pend <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (w_line_end) begin
              if (r_phase || (r_x != XW'(H_ACTIVE))) r_err <= 1'b1;
              r_y     <= w_y_inc;
              r_x     <= '0;
              r_phase <= 1'b0;
            end else if (i_href) begin
              if (!r_phase) begin
                r_hi    <= i_data;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (w_pix_ok) begin
                  r_valid    <= 1'b1;
                  r_pixel    <= {r_hi, i_data};
                  r_sof      <= r_sof_pend;
                  r_sof_pend <= 1'b0;
                  r_eol      <= (r_x == XW'(H_ACTIVE - 1));
                  r_x        <= r_x + XW'(1);
                end else begin
                  r_err <= 1'b1;
                end
              end
            end else begin
              r_phase <= 1'b0;
            end
            if (w_vs_rise) begin
              r_frame_done <= 1'b1;
              if (w_y_end != YW'(V_ACTIVE)) r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_pixel      = r_pixel;
  assign o_sof        = r_sof;
  assign o_eol        = r_eol;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule
